// File: rtl/memory_matrix_pkg.sv
// memory_matrix_pkg
// Shared definitions for the tile board: FSM state encodings for the guess
// scanner, default board-size and debounce constants, and a one-hot test
// that the board generator can also use.
// No ports (package).
package memory_matrix_pkg;

  localparam int N_TILES_DEF         = 8;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;

  // Widest switch vector the one-hot helper accepts; narrower vectors are
  // zero-extended by the caller.
  localparam int MAX_TILES = 64;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } scan_state_t;

  // A non-zero vector with exactly one bit set. Clearing the lowest set bit
  // leaves zero only when a single bit was set.
  function automatic logic is_one_hot(input logic [MAX_TILES-1:0] vec);
    return (vec != '0) && ((vec & (vec - MAX_TILES'(1))) == '0);
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// switch_debouncer
// Two-flop synchroniser plus a vector-wide debouncer with one shared counter.
// A new switch level is accepted only after the synchronised vector has held
// the same value for DEBOUNCE_CYCLES consecutive cycles. Any bit toggling
// restarts the count for the whole vector.
// Ports:
//   clk     system clock
//   reset   synchronous active-high reset
//   sw_raw  asynchronous raw switches, 1 = pressed
//   stable  debounced switch vector
module switch_debouncer #(
  parameter int N_TILES         = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_TILES-1:0] sw_raw,
  output logic [N_TILES-1:0] stable
);

  logic [N_TILES-1:0] sync_meta;
  logic [N_TILES-1:0] sync_out;
  logic [N_TILES-1:0] sync_prev;
  logic [CNT_W-1:0]   cnt;

  // The count only runs while the synchronised vector is unchanged from the
  // previous cycle and differs from the accepted level. Reaching the terminal
  // count commits the new level and rearms the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= '0;
      sync_out  <= '0;
      sync_prev <= '0;
      cnt       <= '0;
      stable    <= '0;
    end else begin
      sync_meta <= sw_raw;
      sync_out  <= sync_meta;
      sync_prev <= sync_out;
      if ((sync_out != sync_prev) || (sync_out == stable)) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync_out;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/tile_guess_scanner.sv
// tile_guess_scanner
// Input front end for the tile board. Debounces the raw switch vector and
// turns each accepted press into exactly one single-cycle guess event
// (one-hot tile plus binary index). Presses with several switches active are
// reported as multi_press instead. A press must be fully released before the
// next one is considered.
// Ports:
//   clk          system clock
//   reset        synchronous active-high reset
//   enable       guess acceptance window
//   sw_raw       asynchronous raw tile switches, 1 = pressed
//   guess_valid  single-cycle pulse for an accepted guess
//   guess_tile   one-hot accepted tile, 0 when guess_valid is low
//   guess_idx    binary index of guess_tile, 0 when guess_valid is low
//   multi_press  single-cycle pulse for a press rejected as multi-switch
//   held         any debounced switch active
module tile_guess_scanner
  import memory_matrix_pkg::*;
#(
  parameter int N_TILES         = N_TILES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 20,
  parameter int IDX_W           = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [N_TILES-1:0] sw_raw,
  output logic               guess_valid,
  output logic [N_TILES-1:0] guess_tile,
  output logic [IDX_W-1:0]   guess_idx,
  output logic               multi_press,
  output logic               held
);

  logic [N_TILES-1:0] stable;
  scan_state_t        state;
  scan_state_t        state_nxt;
  logic [IDX_W-1:0]   idx_enc;
  logic               valid_nxt;
  logic [N_TILES-1:0] tile_nxt;
  logic [IDX_W-1:0]   idx_nxt;
  logic               multi_nxt;

  switch_debouncer #(
    .N_TILES        (N_TILES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debouncer (
    .clk   (clk),
    .reset (reset),
    .sw_raw(sw_raw),
    .stable(stable)
  );

  // held follows the debounced vector directly so it adds no latency.
  assign held = (stable != '0);

  // One-hot to binary encoder. Only meaningful when stable is one-hot; index
  // bits above the tile range stay 0 because i never exceeds N_TILES-1.
  always_comb begin
    idx_enc = '0;
    for (int i = 0; i < N_TILES; i++) begin
      if (stable[i]) begin
        idx_enc = IDX_W'(i);
      end
    end
  end

  // A press is judged once, on the first cycle the debounced vector becomes
  // non-zero in S_IDLE. S_HOLD then swallows everything until a full release,
  // so switches added or dropped mid-press and enable changes have no effect.
  always_comb begin
    state_nxt = state;
    valid_nxt = 1'b0;
    tile_nxt  = '0;
    idx_nxt   = '0;
    multi_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (stable != '0) begin
          state_nxt = S_HOLD;
          if (enable) begin
            if (is_one_hot(MAX_TILES'(stable))) begin
              valid_nxt = 1'b1;
              tile_nxt  = stable;
              idx_nxt   = idx_enc;
            end else begin
              multi_nxt = 1'b1;
            end
          end
        end
      end
      S_HOLD: begin
        if (stable == '0) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and registered event outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      guess_valid <= 1'b0;
      guess_tile  <= '0;
      guess_idx   <= '0;
      multi_press <= 1'b0;
    end else begin
      state       <= state_nxt;
      guess_valid <= valid_nxt;
      guess_tile  <= tile_nxt;
      guess_idx   <= idx_nxt;
      multi_press <= multi_nxt;
    end
  end

endmodule
